bn_channel_scheduler: RTL and testbench
=======================================

// Module: bn_channel_scheduler
// PURPOSE
//  Sequences the per-pixel batch-normalisation element array channel by channel.
//  Holds per-channel gamma/beta/moving_mean/denominator in a local register file.
//  Broadcasts the active channel's set to the array and times the array latency.
//  Handshakes one tile (one channel plane) in and one result out per channel.
// PARAMETERS
//  DATA_WIDTH    32  width of each BN parameter word (IEEE-754 fp32)
//  DEPTH         16  number of channels per pass (>=1)
//  ELEM_LATENCY  4   clock cycles from data_i/params stable to result_o valid in the array (>=0)
// PORTS
//  clk          in   1                   clock
//  rst          in   1                   synchronous, active-high reset
//  cfg_we       in   1                   parameter write strobe
//  cfg_sel      in   2                   0=gamma 1=beta 2=moving_mean 3=denominator
//  cfg_addr     in   CH_W=$clog2(DEPTH)  channel index of write (CH_W=1 when DEPTH=1)
//  cfg_wdata    in   DATA_WIDTH          write data
//  cfg_err      out  1                   1-cycle pulse: write rejected
//  start        in   1                   1-cycle pulse: begin pass over channels 0..DEPTH-1
//  busy         out  1                   high from accepted start until done
//  done         out  1                   1-cycle pulse after last channel's result accepted
//  in_valid     in   1                   upstream tile for current channel present and stable
//  in_ready     out  1                   tile consumed (upstream may advance)
//  gamma_o, beta_o, moving_mean_o, denominator_o  out  DATA_WIDTH  params to array
//  channel_o    out  CH_W                channel currently sequenced
//  out_valid    in/out: out 1            array result_o valid for channel_o
//  out_ready    in   1                   downstream accepts result
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, cfg_err, in_ready, out_valid=0; channel_o=0;
//   regfile: gamma=denominator=BN_ONE (32'h3F80_0000), beta=moving_mean=BN_ZERO.
//  param outputs are registered reads of regfile[channel_o], updated on entry to SETUP.
//  FSM IDLE -> SETUP -> WAIT -> OUT -> (SETUP | DONE) -> IDLE.
//   IDLE: start=1 -> SETUP, channel_o=0, busy=1. start while busy ignored.
//   SETUP: params for channel_o driven; stay until in_valid=1; then load cnt=ELEM_LATENCY,
//    go WAIT (or OUT directly when ELEM_LATENCY=0).
//   WAIT: cnt decrements each cycle; cnt==1 -> OUT. WAIT lasts exactly ELEM_LATENCY cycles.
//   OUT: out_valid=1 (held until handshake); in_ready = out_ready (combinational, OUT only).
//    On out_valid&&out_ready: channel_o==DEPTH-1 -> DONE, else channel_o+1 -> SETUP.
//   DONE: done=1 one cycle, busy=0 -> IDLE.
//  Latency: in_valid sampled in SETUP at cycle t -> out_valid first high at t+1+ELEM_LATENCY.
//  Upstream must hold in_valid and tile data stable from SETUP acceptance until in_ready;
//   in_valid dropping in WAIT/OUT is a protocol violation (assertion, no recovery).
//  cfg_we while busy=1: write dropped, cfg_err pulses next cycle. cfg_we in IDLE on the
//   same cycle as start: write committed, start accepted; new value used.
//  cfg_addr >= DEPTH: write dropped, cfg_err pulses.
//  rst mid-pass: immediate return to IDLE, outputs to reset values, no done pulse;
//   regfile restored to identity values.
// CONFIGURATION
//  BN_PERF_CNT_EN defined: adds outputs stall_cnt (32b) and pass_cnt (16b).
//   stall_cnt increments each cycle in SETUP with in_valid=0 or OUT with out_ready=0;
//   saturates at all-ones; cleared by rst and by accepted start. pass_cnt increments on done.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package bn_ctrl_pkg: BN_ONE, BN_ZERO constants; cfg_sel encoding localparams
//   (SEL_GAMMA..SEL_DENOM); FSM state enum (IDLE, SETUP, WAIT, OUT, DONE).
//  Sub-module bn_param_regfile: 4 x DEPTH x DATA_WIDTH, 1 write port, 1 registered read
//   port of all four words for one channel; reset to identity values.
// TESTING
//  Reset, start with no writes, DEPTH=4: each channel params = 3F800000/0/0/3F800000; done once.
//  Write gamma[2]=40000000, beta[2]=3F000000, run: channel_o=2 shows these; others identity.
//  ELEM_LATENCY=4, in_valid high at SETUP cycle t -> out_valid at t+5; ELEM_LATENCY=0 -> t+1.
//  out_ready low 3 cycles in OUT: out_valid/channel_o/params hold; in_ready low until accept.
//  cfg_we during busy and cfg_addr=DEPTH: no regfile change, cfg_err 1-cycle pulse each.
//  rst asserted in WAIT of channel 1: next cycle IDLE, busy=0, no done; new start restarts at 0.

Source files
------------

// File: rtl/bn_channel_scheduler_pkg.sv
// bn_ctrl_pkg: shared constants, parameter-select encoding and FSM states for the BN channel scheduler
package bn_ctrl_pkg;
  localparam logic [31:0] BN_ONE  = 32'h3F80_0000;
  localparam logic [31:0] BN_ZERO = 32'h0000_0000;
  localparam logic [1:0] SEL_GAMMA = 2'd0;
  localparam logic [1:0] SEL_BETA  = 2'd1;
  localparam logic [1:0] SEL_MEAN  = 2'd2;
  localparam logic [1:0] SEL_DENOM = 2'd3;
  typedef enum logic [2:0] {IDLE, SETUP, WAIT, OUT, DONE} state_t;
  function automatic logic [31:0] bn_identity(input logic [1:0] sel);
    return (sel == SEL_GAMMA || sel == SEL_DENOM) ? BN_ONE : BN_ZERO;
  endfunction
endpackage

// File: rtl/bn_channel_scheduler_regfile.sv
// bn_param_regfile: per-channel gamma/beta/mean/denominator store with one registered four-word read port
module bn_param_regfile
  import bn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CH_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [1:0]            i_sel,
  input  logic [CH_W-1:0]       i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [CH_W-1:0]       i_raddr,
  output logic [DATA_WIDTH-1:0] o_gamma,
  output logic [DATA_WIDTH-1:0] o_beta,
  output logic [DATA_WIDTH-1:0] o_mean,
  output logic [DATA_WIDTH-1:0] o_denom
);
  logic [DATA_WIDTH-1:0] r_mem [4][DEPTH];
  logic [DATA_WIDTH-1:0] r_q [4];
  logic [DATA_WIDTH-1:0] w_rd [4];
  // a write landing on the same cycle as the read must be visible in the read result
  always_comb
    for (int k = 0; k < 4; k++)
      w_rd[k] = (i_we && i_sel == 2'(k) && i_waddr == i_raddr) ? i_wdata : r_mem[k][i_raddr];
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_q[k] <= DATA_WIDTH'(bn_identity(2'(k)));
        for (int c = 0; c < DEPTH; c++) r_mem[k][c] <= DATA_WIDTH'(bn_identity(2'(k)));
      end
    end else begin
      if (i_we) r_mem[i_sel][i_waddr] <= i_wdata;
      if (i_re) for (int k = 0; k < 4; k++) r_q[k] <= w_rd[k];
    end
  assign o_gamma = r_q[SEL_GAMMA];
  assign o_beta  = r_q[SEL_BETA];
  assign o_mean  = r_q[SEL_MEAN];
  assign o_denom = r_q[SEL_DENOM];
endmodule

// File: rtl/bn_channel_scheduler.sv
// bn_channel_scheduler: steps the BN element array through channels 0..DEPTH-1, one tile per channel.
// Optional BN_PERF_CNT_EN adds stall_cnt/pass_cnt performance counters.
module bn_channel_scheduler
  import bn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int ELEM_LATENCY = 4,
  localparam int CH_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_sel,
  input  logic [CH_W-1:0]       cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_err,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] gamma_o,
  output logic [DATA_WIDTH-1:0] beta_o,
  output logic [DATA_WIDTH-1:0] moving_mean_o,
  output logic [DATA_WIDTH-1:0] denominator_o,
  output logic [CH_W-1:0]       channel_o,
  output logic                  out_valid,
`ifdef BN_PERF_CNT_EN
  input  logic                  out_ready,
  output logic [31:0]           stall_cnt,
  output logic [15:0]           pass_cnt
`else
  input  logic                  out_ready
`endif
);
  localparam int LW = ELEM_LATENCY > 0 ? $clog2(ELEM_LATENCY + 1) : 1;
  state_t r_state, w_next;
  logic [CH_W-1:0] r_ch, w_ch_next, w_raddr;
  logic [LW-1:0] r_cnt, w_cnt_next;
  logic w_re, w_cfg_bad, r_cfg_err;
  assign busy      = r_state == SETUP || r_state == WAIT || r_state == OUT;
  assign done      = r_state == DONE;
  assign out_valid = r_state == OUT;
  assign in_ready  = out_valid && out_ready;
  assign channel_o = r_ch;
  assign cfg_err   = r_cfg_err;
  assign w_cfg_bad = cfg_we && (busy || 32'(cfg_addr) >= DEPTH);
  always_comb begin
    w_next     = r_state;
    w_ch_next  = r_ch;
    w_cnt_next = r_cnt;
    w_re       = 1'b0;
    w_raddr    = r_ch;
    unique case (r_state)
      IDLE: if (start) begin
        w_next    = SETUP;
        w_ch_next = '0;
        w_re      = 1'b1;
        w_raddr   = '0;
      end
      SETUP: if (in_valid) begin
        w_cnt_next = LW'(ELEM_LATENCY);
        w_next     = ELEM_LATENCY == 0 ? OUT : WAIT;
      end
      WAIT: begin
        w_cnt_next = r_cnt - LW'(1);
        w_next     = r_cnt == LW'(1) ? OUT : WAIT;
      end
      OUT: if (out_ready) begin
        w_next    = r_ch == CH_W'(DEPTH - 1) ? DONE : SETUP;
        w_ch_next = r_ch == CH_W'(DEPTH - 1) ? r_ch : r_ch + CH_W'(1);
        w_re      = r_ch != CH_W'(DEPTH - 1);
        w_raddr   = r_ch + CH_W'(1);
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_cnt     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ch      <= w_ch_next;
      r_cnt     <= w_cnt_next;
      r_cfg_err <= w_cfg_bad;
    end
  bn_param_regfile #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CH_W(CH_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (cfg_we && !w_cfg_bad),
    .i_sel   (cfg_sel),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_gamma (gamma_o),
    .o_beta  (beta_o),
    .o_mean  (moving_mean_o),
    .o_denom (denominator_o)
  );
`ifdef BN_PERF_CNT_EN
  logic [31:0] r_stall;
  logic [15:0] r_pass;
  assign stall_cnt = r_stall;
  assign pass_cnt  = r_pass;
  always_ff @(posedge clk)
    if (rst) begin
      r_stall <= '0;
      r_pass  <= '0;
    end else begin
      if (r_state == IDLE && start) r_stall <= '0;
      else if (((r_state == SETUP && !in_valid) || (r_state == OUT && !out_ready)) && r_stall != '1)
        r_stall <= r_stall + 32'd1;
      if (r_state == DONE) r_pass <= r_pass + 16'd1;
    end
`endif
  // the tile must stay presented while the array is computing on it
  a_in_valid_hold: assert property (@(posedge clk) disable iff (rst)
    (r_state == WAIT || r_state == OUT) |-> in_valid);
endmodule

// File: tb/tb_bn_channel_scheduler.sv
// tb_bn_channel_scheduler: randomized scoreboard bench for bn_channel_scheduler
module tb_bn_channel_scheduler;
  localparam int DW = 32, DEPTH = 5, LAT = 4, CW = 3;
  localparam logic [31:0] ONE = 32'h3F80_0000;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cfg_we = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [1:0] cfg_sel = 0;
  logic [CW-1:0] cfg_addr = 0;
  logic [DW-1:0] cfg_wdata = 0;
  logic cfg_err, busy, done, in_ready, out_valid;
  logic [DW-1:0] gamma_o, beta_o, mean_o, denom_o;
  logic [CW-1:0] channel_o;
  logic start0 = 0;
  logic cfg_err0, busy0, done0, in_ready0, out_valid0;
  logic [DW-1:0] g0, b0, m0, d0;
  logic [0:0] ch0;
`ifdef BN_PERF_CNT_EN
  logic [31:0] stall_a, stall_b;
  logic [15:0] pass_a, pass_b;
`endif
  bn_channel_scheduler #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ELEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .gamma_o(gamma_o), .beta_o(beta_o),
    .moving_mean_o(mean_o), .denominator_o(denom_o), .channel_o(channel_o),
    .out_valid(out_valid),
`ifdef BN_PERF_CNT_EN
    .stall_cnt(stall_a), .pass_cnt(pass_a),
`endif
    .out_ready(out_ready));
  bn_channel_scheduler #(.DATA_WIDTH(DW), .DEPTH(2), .ELEM_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(1'b0), .cfg_sel(2'd0), .cfg_addr(1'b0),
    .cfg_wdata(32'd0), .cfg_err(cfg_err0), .start(start0), .busy(busy0), .done(done0),
    .in_valid(1'b1), .in_ready(in_ready0), .gamma_o(g0), .beta_o(b0),
    .moving_mean_o(m0), .denominator_o(d0), .channel_o(ch0),
    .out_valid(out_valid0),
`ifdef BN_PERF_CNT_EN
    .stall_cnt(stall_b), .pass_cnt(pass_b),
`endif
    .out_ready(1'b1));

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] g, b, m, d;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [DW-1:0] m_p [4][DEPTH];
  int vectors = 0, errors = 0, cyc = 0, t_in = 0;
  bit exp_done = 0, prev_ov = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < DEPTH; c++) m_p[k][c] = (k == 0 || k == 3) ? ONE : 32'd0;
  endtask

  // monitor: compares every presented result against the scoreboard head, pops on handshake
  always @(negedge clk)
    if (rst) begin
      exp_done = 0;
      prev_ov = 0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        exp_done = 0;
      end else chk("done_quiet", done, 0);
      if (out_valid) begin
        chk("in_ready_follows", in_ready, out_ready);
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = sb[0];
          if (!prev_ov) chk("latency", 64'(cyc - t_in), 64'(1 + LAT));
          chk("channel", channel_o, e.ch);
          chk("gamma", gamma_o, e.g);
          chk("beta", beta_o, e.b);
          chk("moving_mean", mean_o, e.m);
          chk("denominator", denom_o, e.d);
          if (out_ready) begin
            void'(sb.pop_front());
            if (e.ch == CW'(DEPTH - 1)) exp_done = 1;
          end
        end
      end else chk("in_ready_idle", in_ready, 0);
      prev_ov = out_valid;
    end

  task automatic cfg_write(input logic [1:0] s, input logic [CW-1:0] a, input logic [DW-1:0] d,
                           input bit rej);
    cfg_we = 1; cfg_sel = s; cfg_addr = a; cfg_wdata = d;
    if (!rej) m_p[s][a] = d;
    step;
    cfg_we = 0;
    @(negedge clk) chk("cfg_err_pulse", cfg_err, rej);
    step;
    @(negedge clk) chk("cfg_err_clear", cfg_err, 0);
    step;
  endtask

  task automatic handshake(input int stall_n);
    int n;
    bit hs;
    n = 0;
    hs = 0;
    while (!hs && n < 200) begin
      out_ready = (n < stall_n) ? 1'b0 : ($urandom_range(0, 2) != 0);
      @(negedge clk) hs = in_ready;
      step;
      n++;
    end
    out_ready = 0;
    if (!hs) chk("handshake_timeout", 0, 1);
  endtask

  task automatic run_pass(input bit sw, input bit busy_wr, input int stall_ch);
    logic [1:0] s;
    logic [CW-1:0] a;
    logic [DW-1:0] d;
    int dly;
    if (sw) begin
      s = 2'($urandom_range(0, 3)); a = 0; d = $urandom;
      m_p[s][0] = d;
      cfg_we = 1; cfg_sel = s; cfg_addr = a; cfg_wdata = d;
    end
    for (int c = 0; c < DEPTH; c++)
      sb.push_back('{ch: CW'(c), g: m_p[0][c], b: m_p[1][c], m: m_p[2][c], d: m_p[3][c]});
    start = 1;
    step;
    start = 0;
    cfg_we = 0;
    if (sw) begin
      @(negedge clk) chk("cfg_err_with_start", cfg_err, 0);
      step;
    end
    if (busy_wr) cfg_write(2'($urandom_range(0, 3)), CW'($urandom_range(0, DEPTH - 1)), $urandom, 1);
    for (int c = 0; c < DEPTH; c++) begin
      dly = $urandom_range(0, 3);
      if (dly > 0) begin
        in_valid = 0;
        repeat (dly) step;
      end
      in_valid = 1;
      t_in = cyc;
      handshake(c == stall_ch ? LAT + 4 : 0);
    end
    in_valid = 0;
    repeat (2) step;
  endtask

  initial begin
    logic [3:0] tab [6];
    tab = '{4'b0001, 4'b1001, 4'b0101, 4'b1101, 4'b0110, 4'b0100};
    model_reset();
    repeat (3) step;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_channel", channel_o, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_gamma", gamma_o, ONE);
    chk("rst_beta", beta_o, 0);
    chk("rst_mean", mean_o, 0);
    chk("rst_denom", denom_o, ONE);
    chk("rst_busy0", busy0, 0);
    step;
    rst = 0;
    step;
    run_pass(0, 0, -1);
    cfg_write(2'd0, 3'd2, 32'h4000_0000, 0);
    cfg_write(2'd1, 3'd2, 32'h3F00_0000, 0);
    run_pass(0, 0, 2);
    cfg_write(2'd2, 3'(DEPTH), 32'hDEAD_BEEF, 1);
    cfg_write(2'd3, 3'd7, 32'h1234_5678, 1);
    run_pass(0, 1, 1);
    for (int p = 0; p < 4; p++) begin
      for (int w = 0; w < 3; w++) begin
        logic [CW-1:0] a;
        a = CW'($urandom_range(0, 7));
        cfg_write(2'($urandom_range(0, 3)), a, $urandom, 32'(a) >= DEPTH);
      end
      run_pass(p[0], p[1], $urandom_range(0, DEPTH - 1));
    end
    // zero-latency instance: result offered the cycle after the tile is sampled in SETUP
    start0 = 1;
    step;
    start0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lat0_seq", {out_valid0, ch0, done0, busy0}, tab[i]);
      chk("lat0_in_ready", in_ready0, tab[i][3]);
      step;
    end
    // reset while channel 1 is in its latency wait
    for (int c = 0; c < DEPTH; c++)
      sb.push_back('{ch: CW'(c), g: m_p[0][c], b: m_p[1][c], m: m_p[2][c], d: m_p[3][c]});
    start = 1;
    step;
    start = 0;
    in_valid = 1;
    t_in = cyc;
    handshake(0);
    t_in = cyc;
    repeat (2) step;
    @(negedge clk) chk("pre_rst_busy", busy, 1);
    step;
    rst = 1;
    sb.delete();
    model_reset();
    step;
    in_valid = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_channel", channel_o, 0);
    step;
    rst = 0;
    step;
    run_pass(0, 0, -1);
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
